// File: rtl/mag_read_sequencer.sv
// mag_read_sequencer
//
// Turns each SAMPLE_TICK into one coherent magnetometer vector. The block
// latches TIMESTAMP, then reads X, Z and Y (in that order, 2 bytes each)
// through the shared I2C master, with a timeout on every transaction. It then
// publishes the vector with a one-cycle MDATA_VALID pulse.
//
// Optional feature: define MAG_RETRY_EN to give each axis one retry after a
// NACK/bus error or a timeout. Without it, the first failure aborts the sample.
//
// Ports:
//   CLK_48MHZ, RESET_N          clock, asynchronous active-low reset
//   SAMPLE_TICK, TIMESTAMP      sample request and the time to stamp it with
//   I2C_REQ/ADDR/REG            read request towards the I2C master
//   I2C_ACK/DONE/ERR/RDATA      handshake and read data from the I2C master
//   MDATA_X/Y/Z/TS, MDATA_VALID published vector and its update pulse
//   BUSY, OVERRUN, ERR_COUNT    status: active, sticky dropped tick, aborts
module mag_read_sequencer #(
  parameter logic [6:0] DEV_ADDR    = 7'h1E,
  parameter logic [7:0] REG_X       = 8'h03,
  parameter logic [7:0] REG_Z       = 8'h05,
  parameter logic [7:0] REG_Y       = 8'h07,
  parameter int         TIMEOUT_CYC = 4800
) (
  input  logic        CLK_48MHZ,
  input  logic        RESET_N,
  input  logic        SAMPLE_TICK,
  input  logic [31:0] TIMESTAMP,
  output logic        I2C_REQ,
  output logic [6:0]  I2C_ADDR,
  output logic [7:0]  I2C_REG,
  input  logic        I2C_ACK,
  input  logic        I2C_DONE,
  input  logic        I2C_ERR,
  input  logic [15:0] I2C_RDATA,
  output logic [15:0] MDATA_X,
  output logic [15:0] MDATA_Y,
  output logic [15:0] MDATA_Z,
  output logic [31:0] MDATA_TS,
  output logic        MDATA_VALID,
  output logic        BUSY,
  output logic        OVERRUN,
  output logic [7:0]  ERR_COUNT
);

  localparam logic [12:0] TIMEOUT_LIM = 13'(TIMEOUT_CYC);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ     = 3'd1,
    ST_WAIT    = 3'd2,
    ST_STORE   = 3'd3,
    ST_PUBLISH = 3'd4
  } state_t;

  state_t      state_r, state_s;
  logic [1:0]  axis_r, axis_s;      // 0 = X, 1 = Z, 2 = Y
  logic [12:0] cnt_r;
  logic        cap_s, abort_s;
  logic [15:0] sh_x_r, sh_y_r, sh_z_r;
  logic [31:0] sh_ts_r;

  logic        i2c_req_r;
  logic [6:0]  i2c_addr_r;
  logic [7:0]  i2c_reg_r;
  logic [15:0] mdata_x_r, mdata_y_r, mdata_z_r;
  logic [31:0] mdata_ts_r;
  logic        mdata_valid_r, busy_r, overrun_r;
  logic [7:0]  err_count_r;

`ifdef MAG_RETRY_EN
  logic        retry_r, retry_set_s;
`endif

  // Register pointer for a given axis index.
  function automatic logic [7:0] axis_reg(input logic [1:0] axis);
    logic [7:0] r;
    case (axis)
      2'd0:    r = REG_X;
      2'd1:    r = REG_Z;
      2'd2:    r = REG_Y;
      default: r = REG_X;
    endcase
    return r;
  endfunction

  // State, axis index and per-transaction timeout counter.
  always_ff @(posedge CLK_48MHZ or negedge RESET_N) begin
    if (!RESET_N) begin
      state_r <= ST_IDLE;
      axis_r  <= 2'd0;
      cnt_r   <= 13'd0;
    end else begin
      state_r <= state_s;
      axis_r  <= axis_s;
      // Held at zero outside WAIT, so it is clear on the cycle after ACK.
      if (state_r == ST_WAIT) begin
        cnt_r <= cnt_r + 13'd1;
      end else begin
        cnt_r <= 13'd0;
      end
    end
  end

  // Next-state logic and per-cycle control strobes.
  always_comb begin
    state_s = state_r;
    axis_s  = axis_r;
    cap_s   = 1'b0;
    abort_s = 1'b0;
`ifdef MAG_RETRY_EN
    retry_set_s = 1'b0;
`endif
    case (state_r)
      ST_IDLE: begin
        if (SAMPLE_TICK) begin
          axis_s  = 2'd0;
          state_s = ST_REQ;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (I2C_ACK) begin
          state_s = ST_WAIT;
        end else begin
          state_s = ST_REQ;
        end
      end
      ST_WAIT: begin
        // A good DONE takes priority over a timeout in the same cycle.
        if (I2C_DONE && !I2C_ERR) begin
          cap_s   = 1'b1;
          state_s = ST_STORE;
        end else if ((I2C_DONE && I2C_ERR) || (cnt_r == TIMEOUT_LIM)) begin
`ifdef MAG_RETRY_EN
          if (!retry_r) begin
            retry_set_s = 1'b1;
            state_s     = ST_REQ;
          end else begin
            abort_s = 1'b1;
            state_s = ST_IDLE;
          end
`else
          abort_s = 1'b1;
          state_s = ST_IDLE;
`endif
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_STORE: begin
        if (axis_r == 2'd2) begin
          state_s = ST_PUBLISH;
        end else begin
          axis_s  = axis_r + 2'd1;
          state_s = ST_REQ;
        end
      end
      ST_PUBLISH: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

`ifdef MAG_RETRY_EN
  // One retry per axis; the flag clears on every axis advance and new sample.
  always_ff @(posedge CLK_48MHZ or negedge RESET_N) begin
    if (!RESET_N) begin
      retry_r <= 1'b0;
    end else if (retry_set_s) begin
      retry_r <= 1'b1;
    end else if ((state_r == ST_STORE) || (state_r == ST_IDLE)) begin
      retry_r <= 1'b0;
    end
  end
`endif

  // Shadow vector: timestamp on the accepted tick, axis data on a good DONE.
  always_ff @(posedge CLK_48MHZ or negedge RESET_N) begin
    if (!RESET_N) begin
      sh_x_r  <= 16'd0;
      sh_y_r  <= 16'd0;
      sh_z_r  <= 16'd0;
      sh_ts_r <= 32'd0;
    end else begin
      if ((state_r == ST_IDLE) && SAMPLE_TICK) begin
        sh_ts_r <= TIMESTAMP;
      end
      if (cap_s) begin
        case (axis_r)
          2'd0:    sh_x_r <= I2C_RDATA;
          2'd1:    sh_z_r <= I2C_RDATA;
          2'd2:    sh_y_r <= I2C_RDATA;
          default: sh_x_r <= sh_x_r;
        endcase
      end
    end
  end

  // Registered outputs, decoded from the next state so they line up with it.
  always_ff @(posedge CLK_48MHZ or negedge RESET_N) begin
    if (!RESET_N) begin
      i2c_req_r     <= 1'b0;
      i2c_addr_r    <= 7'd0;
      i2c_reg_r     <= 8'd0;
      mdata_x_r     <= 16'd0;
      mdata_y_r     <= 16'd0;
      mdata_z_r     <= 16'd0;
      mdata_ts_r    <= 32'd0;
      mdata_valid_r <= 1'b0;
      busy_r        <= 1'b0;
      overrun_r     <= 1'b0;
      err_count_r   <= 8'd0;
    end else begin
      i2c_req_r     <= (state_s == ST_REQ);
      i2c_addr_r    <= DEV_ADDR;
      busy_r        <= (state_s != ST_IDLE);
      mdata_valid_r <= (state_s == ST_PUBLISH);
      if (state_s == ST_REQ) begin
        i2c_reg_r <= axis_reg(axis_s);
      end
      if (state_s == ST_PUBLISH) begin
        mdata_x_r  <= sh_x_r;
        mdata_y_r  <= sh_y_r;
        mdata_z_r  <= sh_z_r;
        mdata_ts_r <= sh_ts_r;
      end
      if (SAMPLE_TICK && (state_r != ST_IDLE)) begin
        overrun_r <= 1'b1;
      end
      if (abort_s && (err_count_r != 8'hFF)) begin
        err_count_r <= err_count_r + 8'd1;
      end
    end
  end

  assign I2C_REQ     = i2c_req_r;
  assign I2C_ADDR    = i2c_addr_r;
  assign I2C_REG     = i2c_reg_r;
  assign MDATA_X     = mdata_x_r;
  assign MDATA_Y     = mdata_y_r;
  assign MDATA_Z     = mdata_z_r;
  assign MDATA_TS    = mdata_ts_r;
  assign MDATA_VALID = mdata_valid_r;
  assign BUSY        = busy_r;
  assign OVERRUN     = overrun_r;
  assign ERR_COUNT   = err_count_r;

endmodule

// File: tb/tb_mag_read_sequencer.sv
// Directed bench for mag_read_sequencer. The I2C master is played by tasks
// that drive ACK/DONE by hand. Expected values are written out directly.
module tb_mag_read_sequencer;

  localparam int TIMEOUT_CYC = 4800;

  logic        CLK_48MHZ;
  logic        RESET_N;
  logic        SAMPLE_TICK;
  logic [31:0] TIMESTAMP;
  logic        I2C_REQ;
  logic [6:0]  I2C_ADDR;
  logic [7:0]  I2C_REG;
  logic        I2C_ACK;
  logic        I2C_DONE;
  logic        I2C_ERR;
  logic [15:0] I2C_RDATA;
  logic [15:0] MDATA_X, MDATA_Y, MDATA_Z;
  logic [31:0] MDATA_TS;
  logic        MDATA_VALID;
  logic        BUSY;
  logic        OVERRUN;
  logic [7:0]  ERR_COUNT;

  int checks = 0;
  int errors = 0;
  int vcnt   = 0;
  int exp_err = 0;

  mag_read_sequencer #(.TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .CLK_48MHZ(CLK_48MHZ), .RESET_N(RESET_N),
    .SAMPLE_TICK(SAMPLE_TICK), .TIMESTAMP(TIMESTAMP),
    .I2C_REQ(I2C_REQ), .I2C_ADDR(I2C_ADDR), .I2C_REG(I2C_REG),
    .I2C_ACK(I2C_ACK), .I2C_DONE(I2C_DONE), .I2C_ERR(I2C_ERR),
    .I2C_RDATA(I2C_RDATA),
    .MDATA_X(MDATA_X), .MDATA_Y(MDATA_Y), .MDATA_Z(MDATA_Z),
    .MDATA_TS(MDATA_TS), .MDATA_VALID(MDATA_VALID),
    .BUSY(BUSY), .OVERRUN(OVERRUN), .ERR_COUNT(ERR_COUNT)
  );

  initial CLK_48MHZ = 1'b0;
  always #5 CLK_48MHZ = ~CLK_48MHZ;

  // Count MDATA_VALID pulses on the falling edge.
  always @(negedge CLK_48MHZ) begin
    if (MDATA_VALID === 1'b1) vcnt = vcnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK_48MHZ);
    #1;
  endtask

  task automatic start_sample(input logic [31:0] ts);
    TIMESTAMP   = ts;
    SAMPLE_TICK = 1'b1;
    tick();
    SAMPLE_TICK = 1'b0;
    TIMESTAMP   = 32'hDEAD_BEEF;
  endtask

  // One axis transaction: request check, ACK on the 3rd request cycle,
  // then DONE after 'delay' WAIT cycles. Ends just after DONE is sampled.
  task automatic do_axis(input string tag, input logic [7:0] exp_reg, input logic [15:0] data,
                         input logic err, input int delay, input logic inj_tick,
                         input logic stray_done);
    chk({tag, " req"}, 32'(I2C_REQ), 32'd1);
    chk({tag, " reg"}, 32'(I2C_REG), 32'(exp_reg));
    I2C_DONE  = stray_done;
    I2C_RDATA = 16'h5A5A;
    tick();
    I2C_DONE  = 1'b0;
    tick();
    chk({tag, " req hold"}, 32'(I2C_REQ), 32'd1);
    chk({tag, " reg hold"}, 32'(I2C_REG), 32'(exp_reg));
    I2C_ACK = 1'b1;
    tick();
    I2C_ACK = 1'b0;
    chk({tag, " req drop"}, 32'(I2C_REQ), 32'd0);
    for (int i = 0; i < delay; i++) begin
      SAMPLE_TICK = inj_tick && (i == 0);
      tick();
      SAMPLE_TICK = 1'b0;
    end
    I2C_DONE  = 1'b1;
    I2C_ERR   = err;
    I2C_RDATA = data;
    tick();
    I2C_DONE  = 1'b0;
    I2C_ERR   = 1'b0;
    I2C_RDATA = 16'h0000;
  endtask

  // ACK, then no DONE: ends one cycle after the timeout cycle.
  task automatic run_timeout(input string tag);
    chk({tag, " req"}, 32'(I2C_REQ), 32'd1);
    I2C_ACK = 1'b1;
    tick();
    I2C_ACK = 1'b0;
    repeat (TIMEOUT_CYC) tick();
    chk({tag, " busy at limit"}, 32'(BUSY), 32'd1);
    tick();
  endtask

  task automatic abort_sample();
    start_sample(32'h0000_0BAD);
    do_axis("sat X", 8'h03, 16'h0000, 1'b1, 1, 1'b0, 1'b0);
`ifdef MAG_RETRY_EN
    do_axis("sat X retry", 8'h03, 16'h0000, 1'b1, 1, 1'b0, 1'b0);
`endif
    tick();
  endtask

  initial begin
    RESET_N = 1'b0; SAMPLE_TICK = 1'b0; TIMESTAMP = 32'd0;
    I2C_ACK = 1'b0; I2C_DONE = 1'b0; I2C_ERR = 1'b0; I2C_RDATA = 16'd0;
    repeat (2) tick();
    chk("rst req", 32'(I2C_REQ), 32'd0);
    chk("rst busy", 32'(BUSY), 32'd0);
    chk("rst addr", 32'(I2C_ADDR), 32'd0);
    chk("rst valid", 32'(MDATA_VALID), 32'd0);
    chk("rst x", 32'(MDATA_X), 32'd0);
    chk("rst ts", MDATA_TS, 32'd0);
    chk("rst errcnt", 32'(ERR_COUNT), 32'd0);
    chk("rst overrun", 32'(OVERRUN), 32'd0);
    RESET_N = 1'b1;
    tick();
    chk("addr", 32'(I2C_ADDR), 32'h1E);

    // Stray ACK/DONE in IDLE are ignored.
    I2C_ACK = 1'b1; I2C_DONE = 1'b1;
    tick();
    I2C_ACK = 1'b0; I2C_DONE = 1'b0;
    tick();
    chk("stray idle busy", 32'(BUSY), 32'd0);
    chk("stray idle req", 32'(I2C_REQ), 32'd0);

    // Nominal sample.
    start_sample(32'h0000_1234);
    chk("nom busy", 32'(BUSY), 32'd1);
    do_axis("nom X", 8'h03, 16'h0102, 1'b0, 2, 1'b0, 1'b1);
    tick();
    do_axis("nom Z", 8'h05, 16'h0506, 1'b0, 3, 1'b0, 1'b0);
    tick();
    do_axis("nom Y", 8'h07, 16'h0304, 1'b0, 1, 1'b0, 1'b0);
    chk("nom valid early", 32'(MDATA_VALID), 32'd0);
    tick();
    chk("nom valid", 32'(MDATA_VALID), 32'd1);
    chk("nom X", 32'(MDATA_X), 32'h0102);
    chk("nom Z", 32'(MDATA_Z), 32'h0506);
    chk("nom Y", 32'(MDATA_Y), 32'h0304);
    chk("nom TS", MDATA_TS, 32'h0000_1234);
    tick();
    chk("nom valid end", 32'(MDATA_VALID), 32'd0);
    chk("nom busy end", 32'(BUSY), 32'd0);
    chk("nom pulses", 32'(vcnt), 32'd1);
    chk("nom overrun", 32'(OVERRUN), 32'd0);

    // Overrun: a tick during WAIT is dropped.
    start_sample(32'h0000_5678);
    do_axis("ovr X", 8'h03, 16'h8001, 1'b0, 2, 1'b1, 1'b0);
    chk("ovr flag", 32'(OVERRUN), 32'd1);
    tick();
    do_axis("ovr Z", 8'h05, 16'h7FFF, 1'b0, 1, 1'b0, 1'b0);
    tick();
    do_axis("ovr Y", 8'h07, 16'hFFFF, 1'b0, 1, 1'b0, 1'b0);
    tick();
    chk("ovr valid", 32'(MDATA_VALID), 32'd1);
    chk("ovr X", 32'(MDATA_X), 32'h8001);
    chk("ovr Z", 32'(MDATA_Z), 32'h7FFF);
    chk("ovr Y", 32'(MDATA_Y), 32'hFFFF);
    chk("ovr TS", MDATA_TS, 32'h0000_5678);
    repeat (4) tick();
    chk("ovr no 2nd busy", 32'(BUSY), 32'd0);
    chk("ovr no 2nd req", 32'(I2C_REQ), 32'd0);
    chk("ovr pulses", 32'(vcnt), 32'd2);
    chk("ovr sticky", 32'(OVERRUN), 32'd1);

    // NACK on Z.
    start_sample(32'h0000_9ABC);
    do_axis("nack X", 8'h03, 16'h1111, 1'b0, 1, 1'b0, 1'b0);
    tick();
    do_axis("nack Z", 8'h05, 16'hEEEE, 1'b1, 1, 1'b0, 1'b0);
`ifdef MAG_RETRY_EN
    do_axis("nack Z retry", 8'h05, 16'h2222, 1'b0, 1, 1'b0, 1'b0);
    tick();
    do_axis("nack Y", 8'h07, 16'h3333, 1'b0, 1, 1'b0, 1'b0);
    tick();
    chk("retry valid", 32'(MDATA_VALID), 32'd1);
    chk("retry X", 32'(MDATA_X), 32'h1111);
    chk("retry Z", 32'(MDATA_Z), 32'h2222);
    chk("retry Y", 32'(MDATA_Y), 32'h3333);
    chk("retry TS", MDATA_TS, 32'h0000_9ABC);
    tick();
    chk("retry errcnt", 32'(ERR_COUNT), 32'd0);
    chk("retry pulses", 32'(vcnt), 32'd3);
`else
    chk("nack busy", 32'(BUSY), 32'd0);
    chk("nack errcnt", 32'(ERR_COUNT), 32'd1);
    exp_err = 1;
    repeat (3) tick();
    chk("nack req", 32'(I2C_REQ), 32'd0);
    chk("nack pulses", 32'(vcnt), 32'd2);
    chk("nack X hold", 32'(MDATA_X), 32'h8001);
    chk("nack Z hold", 32'(MDATA_Z), 32'h7FFF);
    chk("nack TS hold", MDATA_TS, 32'h0000_5678);
`endif

    // Timeout abort exactly at TIMEOUT_CYC.
    start_sample(32'h0000_0042);
    run_timeout("to X");
`ifdef MAG_RETRY_EN
    chk("to retry reg", 32'(I2C_REG), 32'h03);
    run_timeout("to X retry");
`endif
    chk("to busy", 32'(BUSY), 32'd0);
    chk("to req", 32'(I2C_REQ), 32'd0);
    exp_err = exp_err + 1;
    chk("to errcnt", 32'(ERR_COUNT), 32'(exp_err));

    // DONE in the timeout cycle wins.
    start_sample(32'h0000_0077);
    do_axis("edge X", 8'h03, 16'h4444, 1'b0, TIMEOUT_CYC, 1'b0, 1'b0);
    chk("edge busy", 32'(BUSY), 32'd1);
    tick();
    do_axis("edge Z", 8'h05, 16'h5555, 1'b0, 1, 1'b0, 1'b0);
    tick();
    do_axis("edge Y", 8'h07, 16'h6666, 1'b0, 1, 1'b0, 1'b0);
    tick();
    chk("edge valid", 32'(MDATA_VALID), 32'd1);
    chk("edge X", 32'(MDATA_X), 32'h4444);
    chk("edge TS", MDATA_TS, 32'h0000_0077);
    chk("edge errcnt", 32'(ERR_COUNT), 32'(exp_err));
    tick();

    // ERR_COUNT saturation.
    for (int i = exp_err; i < 255; i++) abort_sample();
    chk("sat 255", 32'(ERR_COUNT), 32'd255);
    abort_sample();
    chk("sat hold", 32'(ERR_COUNT), 32'd255);
    chk("sat X hold", 32'(MDATA_X), 32'h4444);

    // Reset in WAIT.
    start_sample(32'h0000_1111);
    chk("rw req", 32'(I2C_REQ), 32'd1);
    I2C_ACK = 1'b1;
    tick();
    I2C_ACK = 1'b0;
    tick();
    RESET_N = 1'b0;
    #1;
    chk("rw req0", 32'(I2C_REQ), 32'd0);
    chk("rw busy0", 32'(BUSY), 32'd0);
    chk("rw errcnt0", 32'(ERR_COUNT), 32'd0);
    chk("rw overrun0", 32'(OVERRUN), 32'd0);
    chk("rw X0", 32'(MDATA_X), 32'd0);
    chk("rw TS0", MDATA_TS, 32'd0);
    chk("rw reg0", 32'(I2C_REG), 32'd0);
    chk("rw addr0", 32'(I2C_ADDR), 32'd0);
    tick();
    RESET_N = 1'b1;
    tick();
    start_sample(32'h0000_ABCD);
    do_axis("post X", 8'h03, 16'hAAAA, 1'b0, 1, 1'b0, 1'b0);
    tick();
    do_axis("post Z", 8'h05, 16'hBBBB, 1'b0, 1, 1'b0, 1'b0);
    tick();
    do_axis("post Y", 8'h07, 16'hCCCC, 1'b0, 1, 1'b0, 1'b0);
    tick();
    chk("post valid", 32'(MDATA_VALID), 32'd1);
    chk("post X", 32'(MDATA_X), 32'hAAAA);
    chk("post Z", 32'(MDATA_Z), 32'hBBBB);
    chk("post Y", 32'(MDATA_Y), 32'hCCCC);
    chk("post TS", MDATA_TS, 32'h0000_ABCD);
    chk("post errcnt", 32'(ERR_COUNT), 32'd0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
